// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    localparam int XLEN = 32;
    localparam int INC  = 4;

    // A zero word ends the program stream
    localparam logic [XLEN-1:0] END_WORD = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - program stream in and instruction-memory write port out
interface imem_loader_if #(
    parameter int ADDR_W = 32
) ();
    import imem_loader_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [XLEN-1:0]   s_data;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [XLEN-1:0]   im_wdata;

    // Host side: drives the word stream and observes the memory writes
    modport master (
        output s_valid, s_data,
        input  s_ready, im_we, im_addr, im_wdata
    );

    // Loader side
    modport slave (
        input  s_valid, s_data,
        output s_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/imem_loader_rst_stretcher.sv
// rtl/imem_loader_rst_stretcher.sv - down-counter that flags when a reset hold time has elapsed
module rst_stretcher #(
    parameter int HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic hold_done
);

    localparam int W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    logic [W-1:0] cnt;

    // Loading with HOLD-1 means hold_done rises after exactly HOLD cycles
    // following the last load, so the owner can switch state on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(HOLD - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign hold_done = (cnt == '0) && !load;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory while holding the core in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 100,
    parameter int ADDR_W    = 32,
    parameter int RST_HOLD  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    imem_loader_if.slave                   bus,
    output logic                           core_rst,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    output logic                           err_overflow
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    state_t state;
    state_t state_nxt;
    logic   hs;
    logic   hs_word;
    logic   hs_last;
    logic   hold_load;
    logic   hold_done;
    logic   restart;

    assign hs      = bus.s_valid && bus.s_ready;
    assign hs_word = hs && (bus.s_data != END_WORD);
    assign hs_last = hs_word && (word_count == CW'(MAX_WORDS - 1));
    assign restart = start && ((state == IDLE) || (state == RUN));

    // Hold timer restarts on leaving LOAD and on every write, so the core
    // stays in reset until RST_HOLD cycles after whichever came last.
    assign hold_load = ((state == LOAD) && (state_nxt == RELEASE)) || bus.im_we;

    rst_stretcher #(
        .HOLD (RST_HOLD)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .hold_done (hold_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt   = state;
        bus.s_ready = 1'b0;
        core_rst    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (hs && (!hs_word || hs_last)) state_nxt = RELEASE;
            end
            RELEASE: begin
                busy = 1'b1;
                if (hold_done) state_nxt = RUN;
            end
            RUN: begin
                core_rst = 1'b1;
                done     = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write port, word counter and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            bus.im_we <= hs_word;
            if (hs_word) begin
                bus.im_addr  <= ADDR_W'(word_count) * ADDR_W'(INC);
                bus.im_wdata <= bus.s_data;
                word_count   <= word_count + CW'(1);
            end
            if (hs_last) begin
                err_overflow <= 1'b1;
            end
            if (restart) begin
                word_count   <= '0;
                err_overflow <= 1'b0;
            end
        end
    end

endmodule
